sram_compare_engine: RTL and testbench
======================================

Name: sram_compare_engine

Overview:
- Parametrised successor to the single-channel SRAM comparator.
- Fills an internal synchronous SRAM from a write stream, then reads it back in order and compares each word against an expected value.
- Expected value comes either from a reference input port or from a generated address pattern.
- Reports per-word match, saturating mismatch count, first failing address, pass/fail and done. Sits between the data source and status/debug logic in the SRAM test path.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 8, address width.
- DEPTH, 256, number of words; must be ≤ 2**ADDR_W.
- MODE, 1, expected-value source: 0 = ref_i; 1 = address pattern (address zero-extended to DATA_W).
- CNT_W, 16, mismatch counter width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of pointers, counters and flags; RAM contents are kept
- d_i  in  DATA_W  write data
- we  in  1  write request, one word per cycle
- rd  in  1  read-and-compare request, one word per cycle
- ref_i  in  DATA_W  expected data, sampled with rd; used only when MODE=0
- r_o  out  1  match result for the current compare; 1 = match
- r_valid_o  out  1  r_o is valid this cycle
- full_o  out  1  wr_cnt == DEPTH
- ovf_o  out  1  sticky: a write was attempted while full
- done_o  out  1  every written word has been compared
- pass_o  out  1  done_o and mismatch_cnt_o == 0
- mismatch_cnt_o  out  CNT_W  mismatch count, saturating
- first_err_addr_o  out  ADDR_W  address of the first mismatch
- err_seen_o  out  1  sticky: at least one mismatch has occurred

Behaviour:
- Reset (rst=0, asynchronous): every output is 0, wr_ptr=rd_ptr=0, state=IDLE. clr=1 at a clock edge does the same thing synchronously and takes priority over we/rd in that cycle.
- States:
  - IDLE: we → FILL; rd ignored.
  - FILL: we writes and continues; rd with wr_cnt>0 → CHECK.
  - CHECK: rd compares; after the last result → DONE.
  - DONE: holds until clr or rst; we and rd are ignored.
- Write: when we=1 and not full, RAM[wr_ptr] <= d_i and wr_ptr increments. When we=1 and full, the word is dropped and ovf_o <= 1. wr_ptr never wraps.
- we and rd in the same cycle: the write wins and rd is dropped. No compare is issued.
- Read pipeline:
  - Cycle N: rd accepted (rd_ptr < wr_cnt, state FILL or CHECK); RAM is addressed with rd_ptr; expected value (ref_i or rd_ptr) and address are registered; rd_ptr increments.
  - Cycle N+1: RAM data is available.
  - Cycle N+2: r_o = (data == expected) is registered and r_valid_o=1 for one cycle.
- rd with rd_ptr == wr_cnt (all words issued) is ignored; no result is produced.
- Once CHECK is entered, writes are ignored.
- On a mismatch: mismatch_cnt_o increments, saturating at 2**CNT_W-1. If err_seen_o was 0, first_err_addr_o captures the address and err_seen_o <= 1.
- done_o rises in the cycle after the final r_valid_o and stays high. pass_o is registered together with done_o.
- Back-to-back rd gives one result per cycle with no bubbles.
- Reset mid-pipeline discards in-flight compares. No r_valid_o is produced after reset release.

Decomposition:
- Package sram_cmp_pkg: state enum (IDLE, FILL, CHECK, DONE) and MODE constants (MODE_REF=0, MODE_ADDR=1).
- One sub-module, sram_sdp: simple dual-port RAM with one write port, one synchronous read port and 1-cycle read latency, parametrised by DATA_W, ADDR_W and DEPTH.

Test Plan (DATA_W=32, ADDR_W=8, DEPTH=256, CNT_W=16 unless noted):
- MODE=1: write d_i=0..255, then 256 consecutive rd → 256 r_valid_o pulses, all r_o=1. First result 2 cycles after the first rd. done_o=1 one cycle after the last result; pass_o=1; mismatch_cnt_o=0.
- MODE=1: write 0..255 with word 17=0xDEAD and word 200=0x0 → mismatch_cnt_o=2, first_err_addr_o=17, err_seen_o=1, pass_o=0, done_o=1.
- Write 257 words → full_o=1 after the 256th write, ovf_o=1 on the 257th, word 257 is not stored. Readback still passes 256 compares.
- we=rd=1 in one cycle during FILL → the write occurs and no r_valid_o results from that rd. Also: rd with 3 words written, issued 5 times → exactly 3 results, then done_o=1.
- MODE=0: write 4 words 0xA5A5_0000..0003, read with ref_i matching except word 2 → r_o sequence 1,1,0,1; first_err_addr_o=2.
- rst=0 asynchronously in mid-CHECK → all outputs are 0 immediately; no r_valid_o after release. clr in DONE → IDLE with counters 0.

Source files
------------

// File: rtl/sram_cmp_pkg.sv
// sram_cmp_pkg: shared state encoding and expected-value mode selectors for the SRAM compare engine
package sram_cmp_pkg;
  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_e;
  localparam int MODE_REF = 0;
  localparam int MODE_ADDR = 1;
endpackage

// File: rtl/sram_sdp.sv
// sram_sdp: simple dual-port RAM, one write port and one registered read port (1-cycle latency)
module sram_sdp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_o <= mem[raddr];
  end
endmodule

// File: rtl/sram_compare_engine.sv
// sram_compare_engine: fills an SRAM from a write stream, reads it back in order and
// compares each word against ref_i or the address pattern, keeping error statistics.
module sram_compare_engine
  import sram_cmp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter int MODE = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_i,
  input  logic              we,
  input  logic              rd,
  input  logic [DATA_W-1:0] ref_i,
  output logic              r_o,
  output logic              r_valid_o,
  output logic              full_o,
  output logic              ovf_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [CNT_W-1:0]  mismatch_cnt_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic              err_seen_o
);
  localparam int PW = ADDR_W + 1;
  state_e state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic v1_q, v1_d, last1_q, last1_d, last2_q, last2_d;
  logic [DATA_W-1:0] exp1_q, exp1_d, rdata;
  logic [ADDR_W-1:0] addr1_q, addr1_d, first_q, first_d;
  logic r_q, r_d, r_valid_q, r_valid_d, ovf_q, ovf_d, done_q, done_d, pass_q, pass_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic full, wr_ok, wr_en, rd_en, miss;
  always_comb begin
    full = wr_ptr_q == PW'(DEPTH);
    wr_ok = we && (state_q == IDLE || state_q == FILL);
    wr_en = wr_ok && !full;
    // a write in FILL wins over a simultaneous read; in CHECK writes are ignored so rd proceeds
    rd_en = rd && (state_q == CHECK || (state_q == FILL && !we)) && rd_ptr_q < wr_ptr_q;
    miss = v1_q && rdata != exp1_q;
    state_d = last2_q ? DONE : (state_q == IDLE && wr_ok) ? FILL :
              (state_q == FILL && rd_en) ? CHECK : state_q;
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(rd_en);
    ovf_d = ovf_q | (wr_ok && full);
    v1_d = rd_en;
    exp1_d = MODE == MODE_REF ? ref_i : DATA_W'(rd_ptr_q[ADDR_W-1:0]);
    addr1_d = rd_ptr_q[ADDR_W-1:0];
    last1_d = rd_en && rd_ptr_q == wr_ptr_q - PW'(1);
    r_d = v1_q && !miss;
    r_valid_d = v1_q;
    cnt_d = cnt_q + CNT_W'(miss && !(&cnt_q));
    err_d = err_q | miss;
    first_d = (miss && !err_q) ? addr1_q : first_q;
    last2_d = v1_q && last1_q;
    done_d = done_q | last2_q;
    pass_d = done_d && cnt_q == '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || clr) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q <= 1'b0;
      v1_q <= 1'b0;
      exp1_q <= '0;
      addr1_q <= '0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      r_q <= 1'b0;
      r_valid_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
      first_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q <= ovf_d;
      v1_q <= v1_d;
      exp1_q <= exp1_d;
      addr1_q <= addr1_d;
      last1_q <= last1_d;
      last2_q <= last2_d;
      r_q <= r_d;
      r_valid_q <= r_valid_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      first_q <= first_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
  sram_sdp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(wr_en && !clr),
    .waddr(wr_ptr_q[ADDR_W-1:0]),
    .wdata(d_i),
    .raddr(rd_ptr_q[ADDR_W-1:0]),
    .rdata_o(rdata)
  );
  assign r_o = r_q;
  assign r_valid_o = r_valid_q;
  assign full_o = full;
  assign ovf_o = ovf_q;
  assign done_o = done_q;
  assign pass_o = pass_q;
  assign mismatch_cnt_o = cnt_q;
  assign first_err_addr_o = first_q;
  assign err_seen_o = err_q;
endmodule

// File: tb/tb_sram_compare_engine.sv
// tb_sram_compare_engine: directed vectors against an address-pattern instance and a ref_i instance
module tb_sram_compare_engine;
  logic clk = 1'b0, rst = 1'b0, clr = 1'b0, we = 1'b0, rd = 1'b0;
  logic [31:0] d_i = '0, ref_i = '0;
  logic r1, rv1, full1, ovf1, done1, pass1, err1, r0, rv0, full0, ovf0, done0, pass0, err0;
  logic [15:0] cnt1, cnt0;
  logic [7:0] fea1, fea0;
  int n_chk = 0, n_fail = 0, n1 = 0, b1 = 0, n0 = 0;
  logic seq0 [8];
  always #5 clk = ~clk;
  sram_compare_engine #(.MODE(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .d_i(d_i), .we(we), .rd(rd), .ref_i(ref_i),
    .r_o(r1), .r_valid_o(rv1), .full_o(full1), .ovf_o(ovf1), .done_o(done1), .pass_o(pass1),
    .mismatch_cnt_o(cnt1), .first_err_addr_o(fea1), .err_seen_o(err1)
  );
  sram_compare_engine #(.MODE(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .d_i(d_i), .we(we), .rd(rd), .ref_i(ref_i),
    .r_o(r0), .r_valid_o(rv0), .full_o(full0), .ovf_o(ovf0), .done_o(done0), .pass_o(pass0),
    .mismatch_cnt_o(cnt0), .first_err_addr_o(fea0), .err_seen_o(err0)
  );
  always @(negedge clk) begin
    if (rv1) begin
      n1++;
      if (!r1) b1++;
    end
    if (rv0) begin
      if (n0 < 8) seq0[n0] = r0;
      n0++;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] d);
    we = 1'b1;
    d_i = d;
    tick();
    we = 1'b0;
  endtask
  task automatic rdn(input int n);
    rd = 1'b1;
    repeat (n) tick();
    rd = 1'b0;
  endtask
  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n1 = 0;
    b1 = 0;
    n0 = 0;
  endtask
  initial begin
    #12;
    chk("reset_outputs", 64'({r1, rv1, full1, ovf1, done1, pass1, err1, cnt1, fea1}), 64'd0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) wr(32'(i));
    chk("full_after_256", 64'(full1), 64'd1);
    chk("no_ovf_at_256", 64'(ovf1), 64'd0);
    wr(32'h100);
    chk("ovf_on_257", 64'(ovf1), 64'd1);
    rd = 1'b1;
    tick();
    chk("latency_cycle1", 64'(rv1), 64'd0);
    tick();
    chk("latency_cycle2", 64'(rv1), 64'd1);
    repeat (254) tick();
    rd = 1'b0;
    tick();
    chk("last_valid", 64'(rv1), 64'd1);
    chk("done_not_yet", 64'(done1), 64'd0);
    tick();
    chk("valid_ends", 64'(rv1), 64'd0);
    chk("done_after_last", 64'(done1), 64'd1);
    chk("pass_clean", 64'(pass1), 64'd1);
    chk("cnt_clean", 64'(cnt1), 64'd0);
    chk("results_clean", 64'(n1), 64'd256);
    chk("misses_clean", 64'(b1), 64'd0);
    rdn(1);
    repeat (3) tick();
    chk("rd_in_done_ignored", 64'(n1), 64'd256);
    do_clr();
    chk("clr_in_done", 64'({done1, pass1, full1, ovf1, err1, cnt1, fea1}), 64'd0);
    for (int i = 0; i < 256; i++) wr(i == 17 ? 32'hDEAD : i == 200 ? 32'h0 : 32'(i));
    rdn(256);
    repeat (3) tick();
    chk("err_cnt", 64'(cnt1), 64'd2);
    chk("err_first_addr", 64'(fea1), 64'd17);
    chk("err_seen", 64'(err1), 64'd1);
    chk("err_pass", 64'(pass1), 64'd0);
    chk("err_done", 64'(done1), 64'd1);
    chk("err_results", 64'(n1), 64'd256);
    do_clr();
    wr(32'd0);
    wr(32'd1);
    we = 1'b1;
    rd = 1'b1;
    d_i = 32'd2;
    tick();
    we = 1'b0;
    rd = 1'b0;
    repeat (4) tick();
    chk("we_rd_no_result", 64'(n1), 64'd0);
    rdn(5);
    repeat (3) tick();
    chk("three_results", 64'(n1), 64'd3);
    chk("three_misses", 64'(b1), 64'd0);
    chk("three_done", 64'(done1), 64'd1);
    chk("three_pass", 64'(pass1), 64'd1);
    do_clr();
    for (int i = 0; i < 4; i++) wr(32'hA5A5_0000 + 32'(i));
    rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ref_i = i == 2 ? 32'h1234_5678 : 32'hA5A5_0000 + 32'(i);
      tick();
    end
    rd = 1'b0;
    repeat (3) tick();
    chk("ref_results", 64'(n0), 64'd4);
    chk("ref_r0", 64'(seq0[0]), 64'd1);
    chk("ref_r1", 64'(seq0[1]), 64'd1);
    chk("ref_r2", 64'(seq0[2]), 64'd0);
    chk("ref_r3", 64'(seq0[3]), 64'd1);
    chk("ref_first_addr", 64'(fea0), 64'd2);
    chk("ref_cnt", 64'(cnt0), 64'd1);
    chk("ref_done_fail", 64'({done0, pass0}), 64'b10);
    do_clr();
    for (int i = 0; i < 8; i++) wr(32'(i));
    rd = 1'b1;
    repeat (4) tick();
    chk("mid_check_valid", 64'(rv1), 64'd1);
    #2;
    rst = 1'b0;
    rd = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({r1, rv1, full1, ovf1, done1, pass1, err1, cnt1, fea1}), 64'd0);
    n1 = 0;
    #10;
    rst = 1'b1;
    repeat (5) tick();
    chk("no_result_after_reset", 64'(n1), 64'd0);
    chk("no_done_after_reset", 64'(done1), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
